ram_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the single-port 32x8 RAM (`ram`). It accepts read/write requests from two independent clients (A and B) and issues exactly one RAM command at a time on the RAM's shared `addr`/`rd_en`/`wr_en` port. It also returns registered read data to the client that issued the read. The block sits between the two clients and the RAM instance, and drives every RAM input except `clk`/`rst`.

---
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-client round-robin arbiter and sequencer for a single-port
// RAM with registered read data. One RAM command is in flight at a time.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | sample requests, pick a winner, latch its command
// WRITE   | drive ram_wr_en and the owner's gnt for one cycle
// READ    | drive ram_rd_en and the owner's gnt for one cycle
// RESP    | RAM read data is valid; capture it for the owner
module ram_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Requester identifiers, used for both the owner and the priority pointer.
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    logic [1:0]            state_q,    state_d;
    logic                  ptr_q,      ptr_d;
    logic                  owner_q,    owner_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_q,  a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q,  b_rdata_d;

    logic                  any_req;
    logic                  winner;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // Winner selection: a lone requester always wins, otherwise ptr decides.
    always_comb begin
        any_req  = a_req | b_req;
        winner   = OWN_A;
        if (a_req && b_req) begin
            winner = ptr_q;
        end else if (b_req) begin
            winner = OWN_B;
        end
        win_we   = (winner == OWN_B) ? b_we    : a_we;
        win_addr = (winner == OWN_B) ? b_addr  : a_addr;
        win_data = (winner == OWN_B) ? b_wdata : a_wdata;
    end

    // Next-state, command capture and priority pointer update.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d    = winner;
                    ptr_d      = ~winner;
                    cmd_addr_d = win_addr;
                    cmd_data_d = win_data;
                    state_d    = win_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read response capture: RAM data is valid during RESP, so register it
    // for the owner and pulse its rvalid in the following cycle.
    always_comb begin
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        if (state_q == S_RESP) begin
            if (owner_q == OWN_A) begin
                a_rvalid_d = 1'b1;
                a_rdata_d  = ram_data_out;
            end else begin
                b_rvalid_d = 1'b1;
                b_rdata_d  = ram_data_out;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= OWN_A;
            owner_q    <= OWN_A;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    // RAM strobes and grants are decoded from the state so they are
    // mutually exclusive and zero in IDLE and RESP by construction.
    always_comb begin
        ram_wr_en   = (state_q == S_WRITE);
        ram_rd_en   = (state_q == S_READ);
        ram_addr    = cmd_addr_q;
        ram_data_in = cmd_data_q;
        a_gnt       = (ram_wr_en || ram_rd_en) && (owner_q == OWN_A);
        b_gnt       = (ram_wr_en || ram_rd_en) && (owner_q == OWN_B);
        a_rvalid    = a_rvalid_q;
        b_rvalid    = b_rvalid_q;
        a_rdata     = a_rdata_q;
        b_rdata     = b_rdata_q;
    end

    // Structural invariants of the sequencer.
    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        !(ram_rd_en && ram_wr_en));
    a_gnt_excl: assert property (@(posedge clk) disable iff (rst)
        !(a_gnt && b_gnt));
    a_rvalid_excl: assert property (@(posedge clk) disable iff (rst)
        !(a_rvalid && b_rvalid));

endmodule
